// File: rtl/rf_pkg.sv
// rf_pkg - shared definitions for the rename register file.
// Holds default widths, the reserved "no producer" tag and the hard-wired
// zero register index, plus convenience typedefs for the default build.
// Optional feature macro used by this slice: RF_COMMIT_BYPASS_EN.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  localparam int REG_W_DEF = $clog2(NREG_DEF);

  // Tag 0 means "value is current"; register 0 is hard-wired to zero.
  localparam logic [TAG_W_DEF-1:0] ZERO_TAG = '0;
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

  typedef logic [XLEN_DEF-1:0]  data_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [REG_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port - one combinational read port of the rename register file.
// Selects V/Q of the requested register, forces register 0 to value 0 /
// tag 0, and (with RF_COMMIT_BYPASS_EN defined) forwards a same-cycle
// commit whose tag matches the register's current producer tag.
// Ports:
//   rs_i       register index to read
//   v_i, q_i   flattened storage (value and producer tag per register)
//   cm_*_i     commit lanes (used only by the bypass)
//   v_o, q_o   value and producer tag seen by dispatch (q_o = 0 -> ready)
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NCM   = 2,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic [REG_W-1:0]            rs_i,
  input  logic [NREG-1:0][XLEN-1:0]   v_i,
  input  logic [NREG-1:0][TAG_W-1:0]  q_i,
  input  logic [NCM-1:0]              cm_en_i,
  input  logic [NCM-1:0][REG_W-1:0]   cm_rd_i,
  input  logic [NCM-1:0][TAG_W-1:0]   cm_tag_i,
  input  logic [NCM-1:0][XLEN-1:0]    cm_data_i,
  output logic [XLEN-1:0]             v_o,
  output logic [TAG_W-1:0]            q_o
);

  // Register 0 always reads as a ready zero; other registers read storage,
  // optionally overridden by a matching commit (ascending loop, so the
  // highest matching lane wins).
  always_comb begin
    v_o = '0;
    q_o = TAG_W'(ZERO_TAG);
    if (rs_i != REG_W'(ZERO_REG)) begin
      v_o = v_i[rs_i];
      q_o = q_i[rs_i];
`ifdef RF_COMMIT_BYPASS_EN
      for (int c = 0; c < NCM; c++) begin
        if (cm_en_i[c] && (cm_rd_i[c] == rs_i) && (cm_tag_i[c] == q_i[rs_i])) begin
          v_o = cm_data_i[c];
          q_o = TAG_W'(ZERO_TAG);
        end
      end
`endif
    end
  end

`ifndef RF_COMMIT_BYPASS_EN
  // Commit lanes only matter to the bypass; fold them to keep lint quiet.
  logic unused_cm;
  assign unused_cm = ^{cm_en_i, cm_rd_i, cm_tag_i, cm_data_i};
`endif

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile - architectural register file with rename (producer) tags.
// Each register holds a committed value V and producer tag Q (Q = 0 ready).
// Dispatch reads NRP ports combinationally and allocates tags on NAL lanes;
// the ROB writes results on NCM commit lanes and may flush all tags.
// Ports:
//   clk, rst (asynchronous, active-low)
//   rd_rs/rd_v/rd_q           read ports
//   al_en/al_rd/al_tag        alloc lanes (lane index = program order)
//   cm_en/cm_rd/cm_tag/cm_data commit lanes (lane index = program order)
//   rollback                  clear every tag, drop same-cycle allocs
//   pend_cnt                  registered count of registers with Q != 0
// Optional feature macro: RF_COMMIT_BYPASS_EN (same-cycle commit forwarding
// on the read ports).
module rename_regfile
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRP   = 4,
  parameter int NAL   = 2,
  parameter int NCM   = 2,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRP-1:0][REG_W-1:0]  rd_rs,
  output logic [NRP-1:0][XLEN-1:0]   rd_v,
  output logic [NRP-1:0][TAG_W-1:0]  rd_q,
  input  logic [NAL-1:0]             al_en,
  input  logic [NAL-1:0][REG_W-1:0]  al_rd,
  input  logic [NAL-1:0][TAG_W-1:0]  al_tag,
  input  logic [NCM-1:0]             cm_en,
  input  logic [NCM-1:0][REG_W-1:0]  cm_rd,
  input  logic [NCM-1:0][TAG_W-1:0]  cm_tag,
  input  logic [NCM-1:0][XLEN-1:0]   cm_data,
  input  logic                       rollback,
  output logic [REG_W:0]             pend_cnt
);

  logic [NREG-1:0][XLEN-1:0]  v_q, v_d;
  logic [NREG-1:0][TAG_W-1:0] q_q, q_d;
  logic [REG_W:0]             cnt_q, cnt_d;
  logic [NREG-1:0]            clr;

  // Next-state: commits write V (highest lane last, so it wins) and mark a
  // tag clear when the pre-edge tag matches any lane. Allocs then overwrite
  // Q (highest lane wins, beating a clear), and rollback overrides all of it.
  // Register 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    v_d   = v_q;
    q_d   = q_q;
    clr   = '0;
    cnt_d = '0;
    for (int c = 0; c < NCM; c++) begin
      if (cm_en[c] && (cm_rd[c] != REG_W'(ZERO_REG))) begin
        v_d[cm_rd[c]] = cm_data[c];
        if (q_q[cm_rd[c]] == cm_tag[c]) begin
          clr[cm_rd[c]] = 1'b1;
        end
      end
    end
    for (int r = 0; r < NREG; r++) begin
      if (clr[r]) begin
        q_d[r] = TAG_W'(ZERO_TAG);
      end
    end
    if (rollback) begin
      q_d = '0;
    end else begin
      for (int a = 0; a < NAL; a++) begin
        if (al_en[a] && (al_rd[a] != REG_W'(ZERO_REG))) begin
          q_d[al_rd[a]] = al_tag[a];
        end
      end
    end
    for (int r = 0; r < NREG; r++) begin
      if (q_d[r] != TAG_W'(ZERO_TAG)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  // State registers; reset clears values, tags and the pending count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    rf_read_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W),
      .NCM   (NCM),
      .REG_W (REG_W)
    ) u_rp (
      .rs_i      (rd_rs[p]),
      .v_i       (v_q),
      .q_i       (q_q),
      .cm_en_i   (cm_en),
      .cm_rd_i   (cm_rd),
      .cm_tag_i  (cm_tag),
      .cm_data_i (cm_data),
      .v_o       (rd_v[p]),
      .q_o       (rd_q[p])
    );
  end

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile - self-checking bench for rename_regfile (default
// parameters). Table of single-cycle vectors plus hand-written sequences
// for reset, the same-cycle commit bypass (RF_COMMIT_BYPASS_EN) and an
// asynchronous reset in the middle of activity.
module tb_rename_regfile;

  logic                clk;
  logic                rst;
  logic [3:0][4:0]     rd_rs;
  logic [3:0][31:0]    rd_v;
  logic [3:0][3:0]     rd_q;
  logic [1:0]          al_en;
  logic [1:0][4:0]     al_rd;
  logic [1:0][3:0]     al_tag;
  logic [1:0]          cm_en;
  logic [1:0][4:0]     cm_rd;
  logic [1:0][3:0]     cm_tag;
  logic [1:0][31:0]    cm_data;
  logic                rollback;
  logic [5:0]          pend_cnt;

  int errors = 0;
  int checks = 0;

  rename_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .rd_rs    (rd_rs),
    .rd_v     (rd_v),
    .rd_q     (rd_q),
    .al_en    (al_en),
    .al_rd    (al_rd),
    .al_tag   (al_tag),
    .cm_en    (cm_en),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_data  (cm_data),
    .rollback (rollback),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       al_en;
    logic [1:0][4:0]  al_rd;
    logic [1:0][3:0]  al_tag;
    logic [1:0]       cm_en;
    logic [1:0][4:0]  cm_rd;
    logic [1:0][3:0]  cm_tag;
    logic [1:0][31:0] cm_data;
    logic             rb;
    logic [4:0]       rs;
    logic [31:0]      exp_v;
    logic [3:0]       exp_q;
    logic [5:0]       exp_cnt;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  function automatic vec_t mkVec(
    input logic [1:0] ae, input logic [4:0] a0r, input logic [3:0] a0t,
    input logic [4:0] a1r, input logic [3:0] a1t,
    input logic [1:0] ce, input logic [4:0] c0r, input logic [3:0] c0t,
    input logic [31:0] c0d, input logic [4:0] c1r, input logic [3:0] c1t,
    input logic [31:0] c1d, input logic rb, input logic [4:0] rs,
    input logic [31:0] ev, input logic [3:0] eq, input logic [5:0] ec);
    vec_t v;
    v.al_en   = ae;
    v.al_rd   = {a1r, a0r};
    v.al_tag  = {a1t, a0t};
    v.cm_en   = ce;
    v.cm_rd   = {c1r, c0r};
    v.cm_tag  = {c1t, c0t};
    v.cm_data = {c1d, c0d};
    v.rb      = rb;
    v.rs      = rs;
    v.exp_v   = ev;
    v.exp_q   = eq;
    v.exp_cnt = ec;
    return v;
  endfunction

  task automatic setIdle();
    al_en    = '0;
    al_rd    = '0;
    al_tag   = '0;
    cm_en    = '0;
    cm_rd    = '0;
    cm_tag   = '0;
    cm_data  = '0;
    rollback = 1'b0;
  endtask

  task automatic setAllPorts(input logic [4:0] rs);
    for (int p = 0; p < 4; p++) rd_rs[p] = rs;
  endtask

  // Drives one vector's requests for a single rising edge, then goes idle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    al_en    = v.al_en;
    al_rd    = v.al_rd;
    al_tag   = v.al_tag;
    cm_en    = v.cm_en;
    cm_rd    = v.cm_rd;
    cm_tag   = v.cm_tag;
    cm_data  = v.cm_data;
    rollback = v.rb;
    @(posedge clk);
    #1;
    setIdle();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t allocOne(input logic [4:0] r, input logic [3:0] t,
                                    input logic [31:0] ev, input logic [5:0] ec);
    return mkVec(2'b01, r, t, 5'd0, 4'd0, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                 1'b0, r, ev, t, ec);
  endfunction

  initial begin
    vec_t v;
    rst = 1'b0;
    setIdle();
    setAllPorts(5'd0);

    // Cases in program order; each row is followed by a read of rs.
    vecs[0]  = allocOne(5'd5, 4'd3, 32'd0, 6'd1);
    vecs[1]  = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b01, 5'd5, 4'd3, 32'hDEADBEEF, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd5, 32'hDEADBEEF, 4'd0, 6'd0);
    vecs[2]  = allocOne(5'd5, 4'd3, 32'hDEADBEEF, 6'd1);
    vecs[3]  = mkVec(2'b01, 5'd5, 4'd7, 5'd0, 4'd0, 2'b01, 5'd5, 4'd3, 32'h11, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd5, 32'h11, 4'd7, 6'd1);
    vecs[4]  = mkVec(2'b11, 5'd9, 4'd2, 5'd9, 4'd4, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd9, 32'd0, 4'd4, 6'd2);
    vecs[5]  = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b11, 5'd9, 4'd4, 32'hA, 5'd9, 4'd4, 32'hB,
                     1'b0, 5'd9, 32'hB, 4'd0, 6'd1);
    vecs[6]  = mkVec(2'b11, 5'd1, 4'd1, 5'd2, 4'd2, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd2, 32'd0, 4'd2, 6'd3);
    vecs[7]  = mkVec(2'b11, 5'd3, 4'd3, 5'd4, 4'd4, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd4, 32'd0, 4'd4, 6'd5);
    vecs[8]  = mkVec(2'b01, 5'd6, 4'd6, 5'd0, 4'd0, 2'b01, 5'd2, 4'd2, 32'h55, 5'd0, 4'd0, 32'd0,
                     1'b1, 5'd2, 32'h55, 4'd0, 6'd0);
    vecs[9]  = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd6, 32'd0, 4'd0, 6'd0);
    vecs[10] = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd5, 32'h11, 4'd0, 6'd0);
    vecs[11] = mkVec(2'b01, 5'd0, 4'd5, 5'd0, 4'd0, 2'b01, 5'd0, 4'd5, 32'hFFFF, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
    vecs[12] = allocOne(5'd7, 4'd6, 32'd0, 6'd1);
    vecs[13] = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b01, 5'd7, 4'd5, 32'h77, 5'd0, 4'd0, 32'd0,
                     1'b0, 5'd7, 32'h77, 4'd6, 6'd1);
    vecs[14] = mkVec(2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 2'b11, 5'd7, 4'd6, 32'h78, 5'd7, 4'd9, 32'h79,
                     1'b0, 5'd7, 32'h79, 4'd0, 6'd0);

    // Reset is asynchronous: outputs are zero before any clock edge.
    #1;
    checkOutput("reset_cnt_async", 32'(pend_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Every register reads 0/0 on every port after reset.
    for (int r = 0; r < 32; r++) begin
      for (int p = 0; p < 4; p++) rd_rs[p] = 5'((r + p * 8) % 32);
      #1;
      for (int p = 0; p < 4; p++) begin
        checkOutput($sformatf("reset_v r%0d p%0d", (r + p * 8) % 32, p), rd_v[p], 32'd0);
        checkOutput($sformatf("reset_q r%0d p%0d", (r + p * 8) % 32, p), 32'(rd_q[p]), 32'd0);
      end
    end
    checkOutput("reset_cnt", 32'(pend_cnt), 32'd0);

    // Table-driven vectors; rotate which port is compared.
    for (int i = 0; i < NVEC; i++) begin
      setAllPorts(vecs[i].rs);
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_v", i), rd_v[i % 4], vecs[i].exp_v);
      checkOutput($sformatf("vec%0d_q", i), 32'(rd_q[i % 4]), 32'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(pend_cnt), 32'(vecs[i].exp_cnt));
    end

    // Read racing a commit: forwarded only when the bypass is built in.
    setAllPorts(5'd8);
    applyStimulus(allocOne(5'd8, 4'd5, 32'd0, 6'd1));
    checkOutput("byp_pre_q", 32'(rd_q[1]), 32'd5);
    checkOutput("byp_pre_cnt", 32'(pend_cnt), 32'd1);
    @(negedge clk);
    cm_en      = 2'b01;
    cm_rd[0]   = 5'd8;
    cm_tag[0]  = 4'd5;
    cm_data[0] = 32'h1234;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    checkOutput("byp_same_v", rd_v[1], 32'h1234);
    checkOutput("byp_same_q", 32'(rd_q[1]), 32'd0);
`else
    checkOutput("byp_same_v", rd_v[1], 32'd0);
    checkOutput("byp_same_q", 32'(rd_q[1]), 32'd5);
`endif
    @(posedge clk);
    #1;
    setIdle();
    #1;
    checkOutput("byp_post_v", rd_v[2], 32'h1234);
    checkOutput("byp_post_q", 32'(rd_q[2]), 32'd0);
    checkOutput("byp_post_cnt", 32'(pend_cnt), 32'd0);

    // Asynchronous reset mid-run clears tags, values and the count at once.
    v = mkVec(2'b11, 5'd10, 4'd1, 5'd11, 4'd2, 2'b00, 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0,
              1'b0, 5'd10, 32'd0, 4'd1, 6'd2);
    setAllPorts(5'd10);
    applyStimulus(v);
    checkOutput("mid_pre_q", 32'(rd_q[0]), 32'd1);
    checkOutput("mid_pre_cnt", 32'(pend_cnt), 32'd2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_cnt", 32'(pend_cnt), 32'd0);
    checkOutput("mid_rst_q10", 32'(rd_q[0]), 32'd0);
    rd_rs[1] = 5'd11;
    rd_rs[2] = 5'd5;
    rd_rs[3] = 5'd8;
    #1;
    checkOutput("mid_rst_q11", 32'(rd_q[1]), 32'd0);
    checkOutput("mid_rst_v5", rd_v[2], 32'd0);
    checkOutput("mid_rst_v8", rd_v[3], 32'd0);
    // Requests presented while in reset are discarded.
    al_en     = 2'b01;
    al_rd[0]  = 5'd12;
    al_tag[0] = 4'd3;
    @(posedge clk);
    #1;
    setIdle();
    @(negedge clk);
    rst = 1'b1;
    setAllPorts(5'd12);
    #1;
    checkOutput("rst_drop_q", 32'(rd_q[0]), 32'd0);
    checkOutput("rst_drop_cnt", 32'(pend_cnt), 32'd0);
    // First edge after release processes inputs normally.
    applyStimulus(allocOne(5'd12, 4'd3, 32'd0, 6'd1));
    checkOutput("post_rel_q", 32'(rd_q[3]), 32'd3);
    checkOutput("post_rel_cnt", 32'(pend_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with rename tags for the out-of-order core, replacing the single-issue version. Each register holds a committed value V and a producer tag Q; Q = 0 means V is current. It sits between dispatch and the ROB. Dispatch reads operands and allocates destination tags over multiple lanes, and the ROB writes results back over multiple commit lanes and can flush all tags on rollback.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two); REG_W = log2(NREG)
- TAG_W, 4, ROB tag width; tag 0 is reserved as "no producer"
- NRP, 4, read ports
- NAL, 2, alloc lanes (lane index = program order)
- NCM, 2, commit lanes (lane index = program order)

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- rd_rs  in  NRP×REG_W  read register index per port
- rd_v  out  NRP×XLEN  value per port
- rd_q  out  NRP×TAG_W  producer tag per port (0 = ready)
- al_en  in  NAL  alloc valid per lane
- al_rd  in  NAL×REG_W  alloc destination
- al_tag  in  NAL×TAG_W  alloc tag (never 0)
- cm_en  in  NCM  commit valid per lane
- cm_rd  in  NCM×REG_W  commit destination
- cm_tag  in  NCM×TAG_W  committing ROB tag
- cm_data  in  NCM×XLEN  committed value
- rollback  in  1  flush all tags
- pend_cnt  out  REG_W+1  registered count of registers with Q ≠ 0

## Operation
- Storage: V[NREG], Q[NREG]. Register 0 reads V = 0 and Q = 0 at all times and ignores every write.
- Reads are combinational. The port returns V[rs] and Q[rs] of the current state. Allocs in the same cycle are not visible; intra-group dependencies belong to dispatch.
- Commit lane c with rd ≠ 0: V[rd] ← cm_data. Q[rd] ← 0 only if Q[rd] (pre-edge) == cm_tag and no alloc to rd is accepted this cycle.
- Same rd on several commit lanes: the highest lane writes V. The Q clear applies if any lane's tag matches.
- Alloc lane a with rd ≠ 0: Q[rd] ← al_tag. Same rd on several lanes: the highest lane wins. Alloc has priority over a commit clear to the same rd.
- Rollback: every Q ← 0 and all allocs that cycle are dropped. Commits that cycle still write V, because they precede the flush in ROB order.
- pend_cnt: registered popcount of the next-state Q ≠ 0, updated every edge.
- Priority per register, per edge: rollback > alloc > commit-clear for Q. V is written by commit only.

## Timing
- Reset (rst = 0, asynchronous): all V = 0, all Q = 0, pend_cnt = 0. Read outputs therefore show 0/0 immediately.
- Alloc and commit take effect at the next rising edge. A read on the following cycle sees the new state: one cycle latency, no handshake.
- Reset asserted mid-cycle discards any pending alloc or commit. The first edge after release processes inputs normally.
- Inputs are sampled only at the rising edge. No stall is needed because the block accepts every request every cycle.

## Configuration
- RF_COMMIT_BYPASS_EN defined:
  - A read port whose rs ≠ 0 matches a valid commit lane with cm_tag == Q[rs] returns V = cm_data (highest matching lane) and Q = 0 in the same cycle.
  - This removes one cycle from the wakeup of a dispatch read that races with commit.
- Undefined: reads return stored state only. Behaviour is as in Timing.

## Structure
- Shared package (rf_pkg):
  - Defaults for XLEN, TAG_W, REG_W.
  - ZERO_TAG = 0 and ZERO_REG = 0.
  - Typedefs for data_t, tag_t and reg_idx_t.
- One natural sub-module, rf_read_port, instantiated NRP times. It contains the index mux, the register-0 force to zero and the optional commit-bypass compare.
- Top level holds storage, next-state priority logic and the pend_cnt popcount.

## Test plan
- Reset, then read every register on all ports → V = 0, Q = 0, pend_cnt = 0. Assert rst low mid-run after allocs → all Q and pend_cnt return to 0 asynchronously.
- Alloc r5 tag 3; next cycle commit r5 tag 3 data 0xDEADBEEF → Q[5] = 0, V[5] = 0xDEADBEEF, pend_cnt 1 → 0.
- Alloc r5 tag 3, then alloc r5 tag 7 in the same cycle as commit r5 tag 3 data 0x11 → V[5] = 0x11, Q[5] = 7, pend_cnt stays 1.
- Same-cycle alloc lanes 0/1 both r9 (tags 2/4); next cycle commit lanes 0/1 both r9 with tag 4, data 0xA/0xB → Q[9] = 4 after the alloc, then V[9] = 0xB and Q[9] = 0 after the commit.
- Allocs on r1–r4, then rollback with commit r2 data 0x55 and alloc r6 in the same cycle → all Q = 0, V[2] = 0x55, Q[6] = 0, pend_cnt = 0.
- With RF_COMMIT_BYPASS_EN: Q[8] = 5, read r8 while committing r8 tag 5 data 0x1234 → rd_v = 0x1234, rd_q = 0 in the same cycle. Without the macro → rd_q = 5.
